sensor_arbiter: RTL and testbench

SENSOR_ARBITER -- requirements
Module: sensor_arbiter

---
 rtl/sensor_arbiter_if.sv | 33 +++
 rtl/sensor_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sensor_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_arbiter_if.sv
// Requester and sensor-engine bundle shared between the arbiter and its peers.
interface sensor_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  req_mode;
    logic [20:0] req_addr;
    logic [23:0] req_wdata;
    logic [5:0]  req_len;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        wr_next;
    logic        busy;
    logic        eng_start;
    logic        eng_mode;
    logic [6:0]  eng_addr;
    logic [7:0]  eng_wdata;
    logic        eng_data_ready;
    logic [7:0]  eng_read_val;

    modport slave (
        input  req, req_mode, req_addr, req_wdata, req_len, eng_data_ready, eng_read_val,
        output gnt, done, err, rd_data, rd_valid, wr_next, busy,
               eng_start, eng_mode, eng_addr, eng_wdata
    );

    modport master (
        output req, req_mode, req_addr, req_wdata, req_len, eng_data_ready, eng_read_val,
        input  gnt, done, err, rd_data, rd_valid, wr_next, busy,
               eng_start, eng_mode, eng_addr, eng_wdata
    );
endinterface

// File: rtl/sensor_arbiter.sv
// Round-robin arbiter granting three requesters access to one sensor engine,
// with per-byte handshake, timeout abort and a guard interval before completion.
module sensor_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned GUARD   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    sensor_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_gnt;
    logic [1:0]  r_last_gnt;
    logic        r_mode;
    logic [6:0]  r_addr;
    logic [1:0]  r_len;
    logic [2:0]  r_byte_cnt;
    logic [7:0]  r_tmo;
    logic [15:0] r_guard;
    logic        r_abort;
    logic        r_dr_q;
    logic [7:0]  r_rd_data;
    logic        r_rd_valid;
    logic        r_wr_next;
    logic [2:0]  r_done;
    logic [2:0]  r_err;

    logic        w_found;
    logic [1:0]  w_sel;
    logic        w_edge;
    logic        w_last_byte;
    logic [7:0]  w_tmo_inc;
    logic        w_tmo_hit;
    logic        w_guard_end;
    logic [7:0]  w_wdata;

    assign w_edge      = bus.eng_data_ready & ~r_dr_q;
    assign w_last_byte = (r_byte_cnt + 3'd1) == ({1'b0, r_len} + 3'd1);
    assign w_tmo_inc   = (r_tmo == 8'hFF) ? r_tmo : r_tmo + 8'd1;
    assign w_tmo_hit   = 32'(w_tmo_inc) >= TIMEOUT;
    assign w_guard_end = (32'(r_guard) + 32'd1) >= GUARD;

    // Round-robin pick: first pending requester above the last one granted.
    always_comb begin
        w_found = 1'b0;
        w_sel   = 2'd0;
        for (int unsigned k = 1; k <= 3; k++) begin
            if (!w_found && bus.req[2'((32'(r_last_gnt) + k) % 3)]) begin
                w_found = 1'b1;
                w_sel   = 2'((32'(r_last_gnt) + k) % 3);
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a byte edge outranks a timeout on the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_XFER;
            S_XFER: begin
                if (w_edge) begin
                    if (w_last_byte) w_next = S_DRAIN;
                end else if (w_tmo_hit) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: if (w_guard_end) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Write byte follows the live slice of whichever requester holds the grant.
    always_comb begin
        w_wdata = '0;
        case (r_gnt)
            3'b001:  w_wdata = bus.req_wdata[7:0];
            3'b010:  w_wdata = bus.req_wdata[15:8];
            3'b100:  w_wdata = bus.req_wdata[23:16];
            default: w_wdata = '0;
        endcase
    end

    // Grant latch, byte/timeout/guard counters and one-cycle status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gnt      <= '0;
            r_last_gnt <= 2'd2;
            r_mode     <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_tmo      <= '0;
            r_guard    <= '0;
            r_abort    <= 1'b0;
            r_dr_q     <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_next  <= 1'b0;
            r_done     <= '0;
            r_err      <= '0;
        end else begin
            r_dr_q     <= bus.eng_data_ready;
            r_rd_valid <= 1'b0;
            r_wr_next  <= 1'b0;
            r_done     <= '0;
            r_err      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt      <= 3'b001 << w_sel;
                        r_last_gnt <= w_sel;
                        r_mode     <= bus.req_mode[w_sel];
                        r_addr     <= bus.req_addr[7*w_sel +: 7];
                        r_len      <= bus.req_len[2*w_sel +: 2];
                        r_byte_cnt <= '0;
                        r_tmo      <= '0;
                        r_guard    <= '0;
                        r_abort    <= 1'b0;
                    end
                end
                S_XFER: begin
                    if (w_edge) begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        r_tmo      <= '0;
                        if (r_mode) begin
                            r_rd_data  <= bus.eng_read_val;
                            r_rd_valid <= 1'b1;
                        end else begin
                            r_wr_next  <= 1'b1;
                        end
                    end else begin
                        r_tmo <= w_tmo_inc;
                        if (w_tmo_hit) r_abort <= 1'b1;
                    end
                end
                S_DRAIN: r_guard <= r_guard + 16'd1;
                S_DONE: begin
                    if (r_abort) r_err  <= r_gnt;
                    else         r_done <= r_gnt;
                    r_gnt      <= '0;
                    r_byte_cnt <= '0;
                    r_tmo      <= '0;
                    r_guard    <= '0;
                    r_abort    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.wr_next   = r_wr_next;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.eng_start = (r_state == S_XFER);
    assign bus.eng_mode  = r_mode;
    assign bus.eng_addr  = r_addr;
    assign bus.eng_wdata = w_wdata;

endmodule

// File: tb/tb_sensor_arbiter.sv
// Scoreboard bench for sensor_arbiter: directed scenarios plus randomized rounds.
module tb_sensor_arbiter;

    localparam int GUARD_C   = 8;
    localparam int TIMEOUT_C = 255;
    localparam int EV_RD = 0, EV_WR = 1, EV_DONE = 2, EV_ERR = 3;

    typedef struct {
        int         kind;
        int         idx;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sensor_arbiter_if bus();

    sensor_arbiter #(.TIMEOUT(TIMEOUT_C), .GUARD(GUARD_C)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    ev_t        sb[$];
    ev_t        mon_e;
    int         total = 0;
    int         bad   = 0;
    int         model_last = 2;
    logic [6:0] m_addr [3];
    logic       m_mode [3];
    logic [1:0] m_len  [3];
    logic [7:0] m_wdata[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first requester in the mask above the last grant.
    function automatic int pick(input logic [2:0] mask);
        for (int k = 1; k <= 3; k++)
            if (mask[(model_last + k) % 3]) return (model_last + k) % 3;
        return -1;
    endfunction

    task automatic push(input int kind, input int idx, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic drive_reqs(input logic [2:0] mask);
        for (int i = 0; i < 3; i++) begin
            bus.req_mode[i]          = m_mode[i];
            bus.req_addr[7*i +: 7]   = m_addr[i];
            bus.req_wdata[8*i +: 8]  = m_wdata[i];
            bus.req_len[2*i +: 2]    = m_len[i];
        end
        bus.req = mask;
    endtask

    task automatic wait_busy(input logic level, input int limit, input string name);
        int n = 0;
        while (bus.busy !== level && n < limit) begin
            tick;
            n++;
        end
        chk(name, 32'(bus.busy), 32'(level));
    endtask

    task automatic engine_byte(input logic [7:0] v, input int hold,
                               input logic chk_wr, input logic [7:0] wexp);
        repeat ($urandom_range(0, 3)) tick;
        bus.eng_read_val   = v;
        bus.eng_data_ready = 1'b1;
        if (chk_wr) chk("eng_wdata", bus.eng_wdata, wexp);
        repeat (hold) tick;
        bus.eng_data_ready = 1'b0;
        tick;
    endtask

    // Feed every byte of the granted transaction, then wait for release.
    task automatic serve(input int g);
        logic [7:0] v;
        for (int b = 0; b <= int'(m_len[g]); b++) begin
            v = 8'($urandom);
            if (m_mode[g]) push(EV_RD, g, v);
            else           push(EV_WR, g, 8'h00);
            engine_byte(v, $urandom_range(1, 2), !m_mode[g], m_wdata[g]);
        end
        bus.req = '0;
        chk("addr_held", bus.eng_addr, m_addr[g]);
        push(EV_DONE, g, 8'h00);
        wait_busy(1'b0, 40, "busy_release");
    endtask

    logic       prev_rv, prev_wn;
    logic [2:0] prev_done, prev_err;

    // Monitor: every status pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            chk("rd_sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("rd_kind", mon_e.kind, EV_RD);
                chk("rd_data", bus.rd_data, mon_e.data);
                chk("rd_gnt", bus.gnt, 32'(1) << mon_e.idx);
            end
            chk("rd_valid_width", 32'(prev_rv), 0);
        end
        if (bus.wr_next === 1'b1) begin
            chk("wr_sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("wr_kind", mon_e.kind, EV_WR);
                chk("wr_gnt", bus.gnt, 32'(1) << mon_e.idx);
            end
            chk("wr_next_width", 32'(prev_wn), 0);
        end
        if (bus.done !== 3'b000 && bus.done !== 3'bxxx) begin
            chk("done_sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("done_kind", mon_e.kind, EV_DONE);
                chk("done_vec", bus.done, 32'(1) << mon_e.idx);
            end
            chk("done_width", prev_done, 0);
        end
        if (bus.err !== 3'b000 && bus.err !== 3'bxxx) begin
            chk("err_sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("err_kind", mon_e.kind, EV_ERR);
                chk("err_vec", bus.err, 32'(1) << mon_e.idx);
            end
            chk("err_width", prev_err, 0);
        end
        prev_rv   = bus.rd_valid;
        prev_wn   = bus.wr_next;
        prev_done = bus.done;
        prev_err  = bus.err;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         g;
        logic [2:0] mask;
        logic [2:0] seen;
        logic [7:0] v;

        for (int i = 0; i < 3; i++) begin
            m_addr[i] = '0; m_mode[i] = 1'b0; m_len[i] = '0; m_wdata[i] = '0;
        end
        bus.req = '0; bus.req_mode = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_len = '0; bus.eng_data_ready = 1'b0; bus.eng_read_val = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick;
        chk("rst_ctrl", {bus.gnt, bus.done, bus.err, bus.rd_valid, bus.wr_next,
                         bus.busy, bus.eng_start, bus.eng_mode}, 0);
        chk("rst_data", {bus.eng_addr, bus.rd_data, bus.eng_wdata}, 0);
        rst = 1'b0;
        tick;

        // Single read, requester 1
        m_mode[1] = 1'b1; m_addr[1] = 7'h48; m_len[1] = 2'd0; m_wdata[1] = 8'h00;
        drive_reqs(3'b010);
        wait_busy(1'b1, 10, "rd1_grant");
        chk("rd1_gnt", bus.gnt, 3'b010);
        chk("rd1_addr", bus.eng_addr, 7'h48);
        chk("rd1_mode", bus.eng_mode, 1);
        chk("rd1_start", bus.eng_start, 1);
        model_last = 1;
        bus.req = '0;
        push(EV_RD, 1, 8'hA5);
        push(EV_DONE, 1, 8'h00);
        bus.eng_read_val   = 8'hA5;
        bus.eng_data_ready = 1'b1;
        tick;
        chk("rd1_start_fall", bus.eng_start, 0);
        chk("rd1_rdata", bus.rd_data, 8'hA5);
        chk("rd1_rvalid", bus.rd_valid, 1);
        bus.eng_data_ready = 1'b0;
        n = 0;
        while (bus.done[1] !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("rd1_done_delay", n, GUARD_C + 1);
        tick;

        // Three-byte write, requester 0
        m_mode[0] = 1'b0; m_addr[0] = 7'($urandom); m_len[0] = 2'd2; m_wdata[0] = 8'($urandom);
        drive_reqs(3'b001);
        wait_busy(1'b1, 10, "wr_grant");
        chk("wr_gnt0", bus.gnt, 3'b001);
        model_last = 0;
        bus.req = '0;
        for (int b = 0; b < 3; b++) begin
            push(EV_WR, 0, 8'h00);
            engine_byte(8'($urandom), 1, 1'b1, m_wdata[0]);
            chk("wr_mode", bus.eng_mode, 0);
        end
        push(EV_DONE, 0, 8'h00);
        wait_busy(1'b0, 40, "wr_release");

        // data_ready held high over several cycles counts once
        m_mode[2] = 1'b1; m_addr[2] = 7'($urandom); m_len[2] = 2'd1;
        drive_reqs(3'b100);
        wait_busy(1'b1, 10, "hold_grant");
        chk("hold_gnt", bus.gnt, 3'b100);
        model_last = 2;
        bus.req = '0;
        v = 8'($urandom);
        push(EV_RD, 2, v);
        engine_byte(v, 3, 1'b0, 8'h00);
        chk("hold_one_byte", bus.eng_start, 1);
        v = 8'($urandom);
        push(EV_RD, 2, v);
        engine_byte(v, 1, 1'b0, 8'h00);
        push(EV_DONE, 2, 8'h00);
        wait_busy(1'b0, 40, "hold_release");

        // Reset in XFER after one byte
        drive_reqs(3'b100);
        wait_busy(1'b1, 10, "mrst_grant");
        chk("mrst_gnt", bus.gnt, 3'b100);
        bus.req = '0;
        v = 8'($urandom);
        push(EV_RD, 2, v);
        bus.eng_read_val   = v;
        bus.eng_data_ready = 1'b1;
        tick;
        bus.eng_data_ready = 1'b0;
        rst = 1'b1;
        tick;
        chk("mrst_ctrl", {bus.gnt, bus.done, bus.err, bus.rd_valid, bus.wr_next,
                          bus.busy, bus.eng_start, bus.eng_mode}, 0);
        chk("mrst_data", {bus.eng_addr, bus.rd_data}, 0);
        tick;
        rst = 1'b0;
        model_last = 2;
        seen = '0;
        repeat (12) begin
            tick;
            seen = seen | bus.done | bus.err;
        end
        chk("mrst_no_pulse", seen, 0);

        // All three held: grant order 0,1,2,0,1,2
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 1'($urandom); m_addr[i] = 7'($urandom);
            m_len[i] = 2'd0; m_wdata[i] = 8'($urandom);
        end
        drive_reqs(3'b111);
        for (int t = 0; t < 6; t++) begin
            wait_busy(1'b1, 10, "rr_grant");
            chk("rr_order", bus.gnt, 32'(1) << (t % 3));
            model_last = t % 3;
            for (int b = 0; b <= 0; b++) begin
                v = 8'($urandom);
                if (m_mode[t % 3]) push(EV_RD, t % 3, v);
                else               push(EV_WR, t % 3, 8'h00);
                engine_byte(v, 1, !m_mode[t % 3], m_wdata[t % 3]);
            end
            if (t == 5) bus.req = '0;
            push(EV_DONE, t % 3, 8'h00);
            wait_busy(1'b0, 40, "rr_release");
        end
        tick;

        // Randomized rounds; non-granted inputs are scrambled mid-transaction
        for (int r = 0; r < 20; r++) begin
            mask = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                m_mode[i] = 1'($urandom); m_addr[i] = 7'($urandom);
                m_len[i] = 2'($urandom); m_wdata[i] = 8'($urandom);
            end
            drive_reqs(mask);
            g = pick(mask);
            wait_busy(1'b1, 10, "rnd_grant");
            chk("rnd_gnt", bus.gnt, 32'(1) << g);
            chk("rnd_addr", bus.eng_addr, m_addr[g]);
            chk("rnd_mode", bus.eng_mode, m_mode[g]);
            model_last = g;
            bus.req      = 3'($urandom);
            bus.req_mode = 3'($urandom);
            bus.req_addr = 21'($urandom);
            bus.req_len  = 6'($urandom);
            serve(g);
            chk("rnd_wdata_idle", bus.eng_wdata, 0);
        end

        // Engine silent: timeout abort
        mask = 3'($urandom_range(1, 7));
        drive_reqs(mask);
        g = pick(mask);
        wait_busy(1'b1, 10, "tmo_grant");
        chk("tmo_gnt", bus.gnt, 32'(1) << g);
        model_last = g;
        bus.req = '0;
        push(EV_ERR, g, 8'h00);
        n = 0;
        while (bus.eng_start === 1'b1 && n < 400) begin
            n++;
            tick;
        end
        chk("tmo_xfer_cycles", n, TIMEOUT_C);
        wait_busy(1'b0, 40, "tmo_release");

        repeat (5) tick;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
